ci_window_sequencer: RTL and testbench
======================================

# ci_window_sequencer

Raster-scan controller for the MRELBP centre-intensity window datapaths (R2/R4/R6 sum units). It consumes the per-pixel strobe from the upstream stage and tracks column and row position. It issues the load/accumulate/slide enables that drive a K×K running-sum datapath, and it produces the window-valid, datapath-aligned done and frame-complete strobes. One instance sequences one sum datapath; K selects the radius.

## Interface
- COLS, 15, image width in pixels (K ≤ COLS ≤ 1024)
- ROWS, 15, image height in pixels (K ≤ ROWS ≤ 1024)
- K, 13, window side; odd, 3 ≤ K ≤ 15
- DP_LAT, 2, datapath latency in cycles from enable to the result being ready (0 ≤ DP_LAT ≤ 7)

Ports:
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- valid_i  in  1  one raster-order pixel is presented this cycle
- sof_i  in  1  start of frame; qualifies valid_i, and the pixel is (0,0)
- ld_en  out  1  load the accumulator with the new column (col==0)
- cum_en  out  1  accumulate a column (1 ≤ col ≤ K-1)
- sum_en  out  1  slide: add the new column and subtract the oldest (col ≥ K)
- win_valid_o  out  1  a full K×K window ends at the current pixel
- col_o  out  10  column of the current pixel
- row_o  out  10  row of the current pixel
- done_o  out  1  win_valid_o delayed DP_LAT cycles; the datapath result is valid
- frame_done_o  out  1  one-cycle pulse after the last done_o of the frame
- busy_o  out  1  state ≠ IDLE
- sof_err_o  out  1  one-cycle pulse when sof_i arrives mid-frame

## Operation
- States and transitions:
  - IDLE → FILL on valid_i.
  - FILL → RUN on the pixel with row==K-1, col==0.
  - RUN → FLUSH on the pixel (ROWS-1, COLS-1).
  - FLUSH → IDLE when the DP_LAT pipeline is empty; frame_done_o pulses on that transition.
- Counters advance only on valid_i. Gaps in valid_i freeze all state and assert no enables.
- col wraps COLS-1 → 0 with row+1. Row never wraps inside a frame; the last pixel moves the FSM to FLUSH.
- Enables are mutually exclusive and are asserted only for cycles that carry valid_i:
  - ld_en when col==0
  - cum_en when 1 ≤ col ≤ K-1
  - sum_en when col ≥ K
- The enables are asserted in FILL rows as well, because the column sums must prime.
- win_valid_o = valid ∧ row ≥ K-1 ∧ col ≥ K-1. This gives (COLS-K+1)·(ROWS-K+1) windows per frame.
- done_o comes from a DP_LAT-deep shift register fed by win_valid_o. With DP_LAT=0 it equals win_valid_o.
- sof_i with valid_i while in FILL or RUN:
  - pulse sof_err_o
  - abandon the frame: no frame_done_o for it
  - restart at (0,0) in FILL; the sof pixel is processed as (0,0)
  - flush the done pipeline (clear it)
- sof_i in IDLE is normal.
- valid_i during FLUSH starts a new frame and moves the FSM to FILL. The done pipeline keeps draining, and frame_done_o for the old frame still fires when that pipeline empties.
- valid_i without sof_i in IDLE is accepted as (0,0).
- sof_i without valid_i is ignored.

## Timing
- All outputs are registered. ld_en, cum_en, sum_en, win_valid_o, col_o and row_o appear 1 cycle after the valid_i that produced them.
- done_o is 1+DP_LAT cycles after that valid_i.
- frame_done_o asserts the cycle after the final done_o.
- Values during and after reset, until the first valid_i:
  - all outputs 0
  - col_o, row_o = 0
  - state IDLE
  - done shift register cleared
- Reset mid-frame discards everything, with no pulses.
- Back-to-back frames are supported at full rate: frame N+1 pixel (0,0) may arrive on the cycle after pixel (ROWS-1, COLS-1) of frame N.

## Structure
- A shared package `mrelbp_pkg` holds:
  - the state encoding (IDLE, FILL, RUN, FLUSH)
  - CNT_W = 10
  - localparam functions for window count and K-range checks
- One sub-module is natural: `ci_delay_line` (parameterised width/depth shift register with synchronous clear), used for the done pipeline.
- Parameter legality is checked at elaboration: K odd, K ≤ COLS, K ≤ ROWS.

## Test plan
- COLS=ROWS=15, K=13, DP_LAT=2, continuous valid_i for 225 pixels:
  - exactly 9 win_valid_o, at (12..14, 12..14)
  - ld_en 15×, cum_en 180×, sum_en 30×
  - frame_done_o 1 cycle after the 9th done_o
- Same frame with valid_i toggling 1/0 every cycle: identical enable sequence and counts, stretched 2×; no enable on idle cycles.
- sof_i+valid_i at pixel (7,3) mid-frame:
  - sof_err_o pulses
  - no frame_done_o for the aborted frame
  - the next 225 valid pixels produce 9 windows and one frame_done_o
- Two frames back-to-back with DP_LAT=7:
  - 18 done_o
  - two frame_done_o pulses
  - busy_o never drops between the frames
- rst asserted while in RUN at (13,5): all outputs 0 the next cycle, no pulses, and the following frame behaves as in the first scenario.
- K=3, COLS=ROWS=3, DP_LAT=0: a single win_valid_o, coincident with done_o, at (2,2).

Source files
------------

// File: rtl/mrelbp_pkg.sv
// Shared definitions for the MRELBP centre-intensity window sequencers.
// Holds the sequencer state encoding, the position counter width and
// elaboration-time helpers for window geometry and parameter legality.
package mrelbp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } seq_state_t;

    localparam int CNT_W = 10;

    // Number of complete KxK windows in a COLS x ROWS frame.
    function automatic int window_count(input int cols, input int rows, input int k);
        return (cols - k + 1) * (rows - k + 1);
    endfunction

    // Window side must be odd and within the supported radii.
    function automatic bit k_is_legal(input int k);
        return (k >= 3) && (k <= 15) && ((k % 2) == 1);
    endfunction

    // Frame must hold at least one window and fit the position counters.
    function automatic bit dims_are_legal(input int cols, input int rows, input int k);
        return (k <= cols) && (k <= rows) && (cols <= 1024) && (rows <= 1024);
    endfunction

endpackage

// File: rtl/ci_delay_line.sv
// Purpose: W-bit, DEPTH-stage shift register with synchronous clear.
// Latency: DEPTH cycles; DEPTH=0 is a wire.
// Backpressure: none, shifts every cycle.
// Ports: clk, rst (sync, active-high), clr (sync flush), d (in), q (out).
module ci_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctl;
            assign unused_ctl = &{1'b0, clk, rst, clr};
            assign q = d;
        end else begin : g_shift
            logic [W-1:0] sr [DEPTH];

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= d;
                    for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
                end
            end

            assign q = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/ci_window_sequencer.sv
// Purpose: raster-scan sequencer driving one KxK running-sum datapath (load/accumulate/slide).
// Latency: enables, window valid and position 1 cycle after valid_i; done_o 1+DP_LAT cycles.
// Backpressure: none; gaps in valid_i freeze position and state, no enables issued.
// Ports: clk, rst (sync, active-high); valid_i/sof_i pixel strobe in; ld_en/cum_en/sum_en
//        datapath enables; win_valid_o, col_o, row_o current pixel; done_o, frame_done_o,
//        busy_o, sof_err_o status.
module ci_window_sequencer
    import mrelbp_pkg::*;
#(
    parameter int COLS   = 15,
    parameter int ROWS   = 15,
    parameter int K      = 13,
    parameter int DP_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             sof_i,
    output logic             ld_en,
    output logic             cum_en,
    output logic             sum_en,
    output logic             win_valid_o,
    output logic [CNT_W-1:0] col_o,
    output logic [CNT_W-1:0] row_o,
    output logic             done_o,
    output logic             frame_done_o,
    output logic             busy_o,
    output logic             sof_err_o
);

    generate
        if (!k_is_legal(K) || !dims_are_legal(COLS, ROWS, K) || DP_LAT < 0 || DP_LAT > 7) begin : g_bad_params
            $error("ci_window_sequencer: illegal COLS/ROWS/K/DP_LAT combination");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_COL   = CNT_W'(COLS - 1);
    localparam logic [CNT_W-1:0] LAST_ROW   = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] K_M1       = CNT_W'(K - 1);
    localparam logic [3:0]       FLUSH_LOAD = 4'(DP_LAT + 1);

    seq_state_t       state, state_nxt;
    logic [CNT_W-1:0] nxt_col, nxt_row;   // position the next in-frame pixel takes
    logic [3:0]       flush_cnt;          // cycles until the last window leaves done_o

    logic             new_frame, abort, last_pix, load_flush;
    logic [CNT_W-1:0] pix_col, pix_row;
    logic             ld_nxt, cum_nxt, sum_nxt, win_nxt;

    // A pixel outside an active frame, or carrying sof, is always (0,0).
    always_comb begin
        new_frame  = (state == ST_IDLE) || (state == ST_FLUSH) || sof_i;
        abort      = valid_i && sof_i && ((state == ST_FILL) || (state == ST_RUN));
        pix_col    = new_frame ? '0 : nxt_col;
        pix_row    = new_frame ? '0 : nxt_row;
        last_pix   = (pix_col == LAST_COL) && (pix_row == LAST_ROW);
        load_flush = valid_i && !sof_i && (state == ST_RUN) && last_pix;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_nxt    = valid_i && (pix_col == '0);
        cum_nxt   = valid_i && (pix_col != '0) && (pix_col <= K_M1);
        sum_nxt   = valid_i && (pix_col > K_M1);
        win_nxt   = valid_i && (pix_row >= K_M1) && (pix_col >= K_M1);
        case (state)
            ST_IDLE: begin
                if (valid_i) state_nxt = ST_FILL;
            end
            ST_FILL: begin
                if (valid_i && !sof_i && (pix_row == K_M1) && (pix_col == '0))
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (abort)           state_nxt = ST_FILL;
                else if (load_flush) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (valid_i)                state_nxt = ST_FILL;
                else if (flush_cnt == 4'd1) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    logic win_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            nxt_col      <= '0;
            nxt_row      <= '0;
            flush_cnt    <= '0;
            ld_en        <= 1'b0;
            cum_en       <= 1'b0;
            sum_en       <= 1'b0;
            win_q        <= 1'b0;
            col_o        <= '0;
            row_o        <= '0;
            frame_done_o <= 1'b0;
            busy_o       <= 1'b0;
            sof_err_o    <= 1'b0;
        end else begin
            ld_en        <= ld_nxt;
            cum_en       <= cum_nxt;
            sum_en       <= sum_nxt;
            win_q        <= win_nxt;
            sof_err_o    <= abort;
            busy_o       <= (state_nxt != ST_IDLE);
            frame_done_o <= (flush_cnt == 4'd1);

            // The flush countdown keeps running across a new frame started in
            // FLUSH so the previous frame still reports completion.
            if (load_flush)            flush_cnt <= FLUSH_LOAD;
            else if (flush_cnt != '0)  flush_cnt <= flush_cnt - 4'd1;

            if (valid_i) begin
                col_o <= pix_col;
                row_o <= pix_row;
                if (pix_col == LAST_COL) begin
                    nxt_col <= '0;
                    nxt_row <= last_pix ? '0 : pix_row + CNT_W'(1);
                end else begin
                    nxt_col <= pix_col + CNT_W'(1);
                    nxt_row <= pix_row;
                end
            end
        end
    end

    assign win_valid_o = win_q;

    // Windows of an abandoned frame must not reach the datapath consumer.
    ci_delay_line #(.W(1), .DEPTH(DP_LAT)) u_done_dly (
        .clk (clk),
        .rst (rst),
        .clr (abort),
        .d   (win_q),
        .q   (done_o)
    );

endmodule

// File: tb/tb_ci_window_sequencer.sv
// Bench for ci_window_sequencer: three instances (K=13/DP_LAT=2, K=13/DP_LAT=7,
// K=3/DP_LAT=0) against a pixel-index model with cycle-stamped done/frame_done
// schedules, plus hand-computed frame totals.
module tb_ci_window_sequencer;

    localparam int NI = 3;
    localparam int HL = 8192;
    localparam int P_COLS [NI] = '{15, 15, 3};
    localparam int P_ROWS [NI] = '{15, 15, 3};
    localparam int P_K    [NI] = '{13, 13, 3};
    localparam int P_DP   [NI] = '{2, 7, 0};

    // counter slots
    localparam int C_LD = 0, C_CUM = 1, C_SUM = 2, C_WV = 3, C_DN = 4;
    localparam int C_FD = 5, C_ERR = 6, C_IDLE = 7, C_COIN = 8, C_WPOS = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vld [NI];
    logic sof [NI];
    logic ld [NI], cum [NI], sm [NI], wv [NI], dn [NI], fd [NI], bz [NI], er [NI];
    logic [9:0] col [NI];
    logic [9:0] row [NI];

    always #5 clk = ~clk;

    ci_window_sequencer #(.COLS(15), .ROWS(15), .K(13), .DP_LAT(2)) u0 (
        .clk(clk), .rst(rst), .valid_i(vld[0]), .sof_i(sof[0]),
        .ld_en(ld[0]), .cum_en(cum[0]), .sum_en(sm[0]), .win_valid_o(wv[0]),
        .col_o(col[0]), .row_o(row[0]), .done_o(dn[0]), .frame_done_o(fd[0]),
        .busy_o(bz[0]), .sof_err_o(er[0]));

    ci_window_sequencer #(.COLS(15), .ROWS(15), .K(13), .DP_LAT(7)) u1 (
        .clk(clk), .rst(rst), .valid_i(vld[1]), .sof_i(sof[1]),
        .ld_en(ld[1]), .cum_en(cum[1]), .sum_en(sm[1]), .win_valid_o(wv[1]),
        .col_o(col[1]), .row_o(row[1]), .done_o(dn[1]), .frame_done_o(fd[1]),
        .busy_o(bz[1]), .sof_err_o(er[1]));

    ci_window_sequencer #(.COLS(3), .ROWS(3), .K(3), .DP_LAT(0)) u2 (
        .clk(clk), .rst(rst), .valid_i(vld[2]), .sof_i(sof[2]),
        .ld_en(ld[2]), .cum_en(cum[2]), .sum_en(sm[2]), .win_valid_o(wv[2]),
        .col_o(col[2]), .row_o(row[2]), .done_o(dn[2]), .frame_done_o(fd[2]),
        .busy_o(bz[2]), .sof_err_o(er[2]));

    // ---------------- model ----------------
    int  cyc = 0;
    bit  exp_done [NI][HL];
    bit  exp_fd   [NI][HL];
    bit  m_act [NI];
    int  m_idx [NI];
    int  m_fdc [NI];
    bit  e_ld [NI], e_cum [NI], e_sum [NI], e_wv [NI], e_busy [NI], e_err [NI];
    int  e_col [NI], e_row [NI];

    always @(posedge clk) begin
        int c, r;
        cyc = cyc + 1;
        for (int i = 0; i < NI; i++) begin
            e_ld[i] = 0; e_cum[i] = 0; e_sum[i] = 0; e_wv[i] = 0; e_err[i] = 0;
            if (rst) begin
                m_act[i] = 0; m_idx[i] = 0; m_fdc[i] = 0;
                e_col[i] = 0; e_row[i] = 0; e_busy[i] = 0;
                for (int m = cyc; m < HL; m++) begin
                    exp_done[i][m] = 0;
                    exp_fd[i][m]   = 0;
                end
            end else begin
                if (vld[i]) begin
                    if (sof[i] && m_act[i]) begin
                        e_err[i] = 1;
                        for (int m = cyc; m < HL; m++) exp_done[i][m] = 0;
                    end
                    if (sof[i] || !m_act[i]) begin
                        m_idx[i] = 0;
                        m_act[i] = 1;
                    end
                    c = m_idx[i] % P_COLS[i];
                    r = m_idx[i] / P_COLS[i];
                    e_col[i] = c;
                    e_row[i] = r;
                    e_ld[i]  = (c == 0);
                    e_cum[i] = (c >= 1) && (c <= P_K[i] - 1);
                    e_sum[i] = (c >= P_K[i]);
                    e_wv[i]  = (r >= P_K[i] - 1) && (c >= P_K[i] - 1);
                    if (e_wv[i] && cyc + P_DP[i] < HL) exp_done[i][cyc + P_DP[i]] = 1;
                    m_idx[i] = m_idx[i] + 1;
                    if (m_idx[i] == P_ROWS[i] * P_COLS[i]) begin
                        m_act[i] = 0;
                        m_fdc[i] = cyc + P_DP[i] + 1;
                        if (m_fdc[i] < HL) exp_fd[i][m_fdc[i]] = 1;
                    end
                end
                e_busy[i] = m_act[i] || (cyc < m_fdc[i]);
            end
        end
    end

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;
    int cnt  [NI][10];
    int base [NI][10];
    int last_dn [NI];
    int last_fd [NI];

    task automatic chk(input string nm, input int got, input int exp);
        n_chk = n_chk + 1;
        if (got == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    endtask

    // Compare every instance at mid-cycle, tally output events, then step one cycle.
    task automatic tick();
        logic [27:0] got, exp;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            got = {ld[i], cum[i], sm[i], wv[i], dn[i], fd[i], bz[i], er[i], col[i], row[i]};
            exp = {e_ld[i], e_cum[i], e_sum[i], e_wv[i], exp_done[i][cyc], exp_fd[i][cyc],
                   e_busy[i], e_err[i], 10'(e_col[i]), 10'(e_row[i])};
            n_chk = n_chk + 1;
            if (got === exp) n_pass = n_pass + 1;
            else $display("FAIL cycle_outputs inst=%0d cyc=%0d got=%h expected=%h", i, cyc, got, exp);
            if (ld[i])  cnt[i][C_LD]++;
            if (cum[i]) cnt[i][C_CUM]++;
            if (sm[i])  cnt[i][C_SUM]++;
            if (wv[i])  cnt[i][C_WV]++;
            if (dn[i])  begin cnt[i][C_DN]++; last_dn[i] = cyc; end
            if (fd[i])  begin cnt[i][C_FD]++; last_fd[i] = cyc; end
            if (er[i])  cnt[i][C_ERR]++;
            if (!bz[i]) cnt[i][C_IDLE]++;
            if (wv[i] && dn[i]) cnt[i][C_COIN]++;
            if (wv[i] && int'(col[i]) >= P_K[i] - 1 && int'(col[i]) <= P_COLS[i] - 1 &&
                int'(row[i]) >= P_K[i] - 1 && int'(row[i]) <= P_ROWS[i] - 1)
                cnt[i][C_WPOS]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input int i);
        for (int k = 0; k < 10; k++) base[i][k] = cnt[i][k];
    endtask

    function automatic int dlt(input int i, input int k);
        return cnt[i][k] - base[i][k];
    endfunction

    task automatic pix(input int i, input logic v, input logic s);
        vld[i] = v;
        sof[i] = s;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < NI; i++) begin vld[i] = 0; sof[i] = 0; end
        repeat (n) tick();
    endtask

    task automatic frame(input int i, input bit toggle);
        for (int p = 0; p < P_ROWS[i] * P_COLS[i]; p++) begin
            pix(i, 1'b1, p == 0);
            if (toggle) pix(i, 1'b0, 1'b0);
        end
    endtask

    // Totals for one clean 15x15, K=13 frame on instance 0.
    task automatic check_k13_frame(input string nm);
        chk({nm, "_win_valid"}, dlt(0, C_WV), 9);
        chk({nm, "_win_pos"},   dlt(0, C_WPOS), 9);
        chk({nm, "_ld_en"},     dlt(0, C_LD), 15);
        chk({nm, "_cum_en"},    dlt(0, C_CUM), 180);
        chk({nm, "_sum_en"},    dlt(0, C_SUM), 30);
        chk({nm, "_done"},      dlt(0, C_DN), 9);
        chk({nm, "_frame_done"}, dlt(0, C_FD), 1);
        chk({nm, "_fd_after_done"}, last_fd[0] - last_dn[0], 1);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            vld[i] = 0; sof[i] = 0; last_dn[i] = 0; last_fd[i] = 0;
            for (int k = 0; k < 10; k++) begin cnt[i][k] = 0; base[i][k] = 0; end
        end
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_flags", int'({ld[0], cum[0], sm[0], wv[0], dn[0], fd[0], bz[0], er[0]}), 0);
        chk("reset_col", int'(col[0]), 0);
        chk("reset_row", int'(row[0]), 0);
        rst = 1'b0;
        idle(2);

        // continuous frame
        snap(0);
        frame(0, 1'b0);
        idle(15);
        check_k13_frame("cont");

        // valid toggling every cycle
        snap(0);
        frame(0, 1'b1);
        idle(15);
        check_k13_frame("toggle");

        // sof mid-frame at (row 7, col 3), then a full frame from the sof pixel
        snap(0);
        for (int p = 0; p < 7 * 15 + 3; p++) pix(0, 1'b1, p == 0);
        frame(0, 1'b0);
        idle(15);
        chk("abort_sof_err", dlt(0, C_ERR), 1);
        chk("abort_windows", dlt(0, C_WV), 9);
        chk("abort_done", dlt(0, C_DN), 9);
        chk("abort_frame_done", dlt(0, C_FD), 1);

        // reset while in RUN at (13,5)
        snap(0);
        for (int p = 0; p <= 13 * 15 + 5; p++) pix(0, 1'b1, p == 0);
        vld[0] = 0; sof[0] = 0;
        rst = 1'b1;
        tick();
        chk("rst_mid_flags", int'({ld[0], cum[0], sm[0], wv[0], dn[0], fd[0], bz[0], er[0]}), 0);
        chk("rst_mid_pos", int'({col[0], row[0]}), 0);
        rst = 1'b0;
        idle(15);
        chk("rst_mid_no_frame_done", dlt(0, C_FD), 0);
        chk("rst_mid_no_err", dlt(0, C_ERR), 0);
        snap(0);
        frame(0, 1'b0);
        idle(15);
        check_k13_frame("post_rst");

        // back-to-back frames, DP_LAT=7
        snap(1);
        pix(1, 1'b1, 1'b1);
        base[1][C_IDLE] = cnt[1][C_IDLE];
        for (int p = 1; p < 450; p++) pix(1, 1'b1, (p % 225) == 0);
        chk("b2b_busy_drops", dlt(1, C_IDLE), 0);
        idle(20);
        chk("b2b_windows", dlt(1, C_WV), 18);
        chk("b2b_done", dlt(1, C_DN), 18);
        chk("b2b_frame_done", dlt(1, C_FD), 2);
        chk("b2b_sof_err", dlt(1, C_ERR), 0);

        // K=3, 3x3, DP_LAT=0
        snap(2);
        frame(2, 1'b0);
        idle(5);
        chk("k3_windows", dlt(2, C_WV), 1);
        chk("k3_win_at_2_2", dlt(2, C_WPOS), 1);
        chk("k3_done_coincident", dlt(2, C_COIN), 1);
        chk("k3_frame_done", dlt(2, C_FD), 1);
        chk("k3_fd_after_done", last_fd[2] - last_dn[2], 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
